// File: rtl/coax_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Coax receiver framing controller: buffers received words one deep, tags
// sof/eof for the downstream FIFO and reports receive errors with a marker word.
module coax_rx_frame_ctrl #(
  parameter int MAX_FRAME_WORDS = 32,
  parameter int WORD_TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        rx_active,
  input  logic        rx_error,
  input  logic        rx_strobe,
  input  logic [9:0]  rx_data,
  output logic        rx_reset,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [12:0] fifo_data,
  output logic        frame_done,
  output logic [5:0]  frame_words,
  output logic        error,
  output logic [2:0]  error_code,
  input  logic        error_ack
);
  localparam int              TW    = $clog2(WORD_TIMEOUT + 1);
  localparam logic [5:0]      MAXW  = 6'(MAX_FRAME_WORDS);
  localparam logic [TW-1:0]   TLAST = TW'(WORD_TIMEOUT - 1);
  localparam logic [2:0]      E_NONE  = 3'd0;
  localparam logic [2:0]      E_RXERR = 3'd1;
  localparam logic [2:0]      E_OVFL  = 3'd2;
  localparam logic [2:0]      E_FULL  = 3'd3;
  localparam logic [2:0]      E_TOUT  = 3'd4;

  typedef enum logic [2:0] {S_DISABLED, S_IDLE, S_RECEIVE, S_ERROR, S_RECOVER} state_t;

  state_t          r_state;
  logic [5:0]      r_count;
  logic [9:0]      r_hold;
  logic [TW-1:0]   r_timer;
  logic            r_marker_done;
  logic            r_rec;
  logic            r_rx_reset;
  logic            r_error;
  logic [2:0]      r_err_code;
  logic [9:0]      r_err_payload;
  logic [5:0]      r_frame_words;

  logic            w_sof;
  logic            w_strobe_wr;
  logic            w_end_wr;
  logic            w_timeout;
  logic [2:0]      w_err;
  logic            w_wr;
  logic [12:0]     w_data;
  logic            w_done;

  // The write path is decoded combinationally so that a write can honour the
  // fifo_full level of the very cycle it is issued in.
  always_comb begin
    w_sof       = (r_count == 6'd1);
    w_strobe_wr = rx_active && rx_strobe && (r_count != '0);
    w_end_wr    = !rx_active && (r_count != '0);
    w_timeout   = rx_active && !rx_strobe && (r_timer == TLAST);
    w_err       = E_NONE;
    w_wr        = 1'b0;
    w_data      = '0;
    w_done      = 1'b0;
    if (enable) begin
      case (r_state)
        S_RECEIVE: begin
          if (rx_error)
            w_err = E_RXERR;
          else if (rx_active && rx_strobe && (r_count == MAXW))
            w_err = E_OVFL;
          else if ((w_strobe_wr || w_end_wr) && fifo_full)
            w_err = E_FULL;
          else if (w_timeout)
            w_err = E_TOUT;
          else if (w_strobe_wr || w_end_wr) begin
            w_wr   = 1'b1;
            w_data = {1'b0, w_sof, w_end_wr, r_hold};
            w_done = w_end_wr;
          end
        end
        S_ERROR: begin
          if (!r_marker_done && !fifo_full) begin
            w_wr   = 1'b1;
            w_data = {3'b101, r_err_payload};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_DISABLED;
      r_count       <= '0;
      r_hold        <= '0;
      r_timer       <= '0;
      r_marker_done <= 1'b0;
      r_rec         <= 1'b0;
      r_rx_reset    <= 1'b1;
      r_error       <= 1'b0;
      r_err_code    <= '0;
      r_err_payload <= '0;
      r_frame_words <= '0;
    end else if (!enable) begin
      r_state       <= S_DISABLED;
      r_rx_reset    <= 1'b1;
      r_error       <= 1'b0;
      r_count       <= '0;
      r_hold        <= '0;
      r_timer       <= '0;
      r_marker_done <= 1'b0;
      r_rec         <= 1'b0;
    end else begin
      case (r_state)
        S_DISABLED: begin
          r_state    <= S_IDLE;
          r_rx_reset <= 1'b0;
        end
        S_IDLE: begin
          r_count <= '0;
          r_hold  <= '0;
          r_timer <= '0;
          if (rx_active) r_state <= S_RECEIVE;
        end
        S_RECEIVE: begin
          if (w_err != E_NONE) begin
            r_state       <= S_ERROR;
            r_rx_reset    <= 1'b1;
            r_error       <= 1'b1;
            r_err_code    <= w_err;
            r_err_payload <= (w_err == E_RXERR) ? rx_data : {7'd0, w_err};
            r_marker_done <= 1'b0;
            r_count       <= '0;
            r_hold        <= '0;
            r_timer       <= '0;
          end else if (!rx_active) begin
            r_state <= S_IDLE;
            if (w_done) r_frame_words <= r_count;
          end else if (rx_strobe) begin
            r_hold  <= rx_data;
            r_count <= r_count + 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ERROR: begin
          if (w_wr)
            r_marker_done <= 1'b1;
          else if (r_marker_done && error_ack) begin
            r_state <= S_RECOVER;
            r_error <= 1'b0;
            r_rec   <= 1'b0;
          end
        end
        S_RECOVER: begin
          if (r_rec) begin
            r_state    <= S_IDLE;
            r_rx_reset <= 1'b0;
          end else begin
            r_rec <= 1'b1;
          end
        end
        default: r_state <= S_DISABLED;
      endcase
    end
  end

  assign rx_reset    = r_rx_reset;
  assign fifo_wr     = w_wr;
  assign fifo_data   = w_data;
  assign frame_done  = w_done;
  assign frame_words = r_frame_words;
  assign error       = r_error;
  assign error_code  = r_err_code;

endmodule
